// File: rtl/aes_key_expand_if.sv
// Handshake/bus bundle between the AES-128 key schedule and its round-key consumer.
interface aes_key_expand_if;
  localparam int unsigned KEY_W = 128;
  localparam int unsigned IDX_W = 4;

  logic             start;
  logic [KEY_W-1:0] key_in;
  logic [KEY_W-1:0] round_key;
  logic [IDX_W-1:0] round_idx;
  logic             key_valid;
  logic             key_ready;
  logic             busy;
  logic             done;

  // master: requester/consumer side; slave: the key schedule
  modport master (
    output start, key_in, key_ready,
    input  round_key, round_idx, key_valid, busy, done
  );

  modport slave (
    input  start, key_in, key_ready,
    output round_key, round_idx, key_valid, busy, done
  );
endinterface

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: accepts one cipher key and streams round keys 0..10,
// computing each next round key on the fly as the current one is accepted.
module aes_key_expand (
  input  logic               clk,
  input  logic               rst,
  aes_key_expand_if.slave    bus
);
  localparam int unsigned NR     = 10;
  localparam int unsigned KEY_W  = 128;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned WORD_W = 32;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [KEY_W-1:0] key_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             valid_reg;
  logic             busy_reg;
  logic             done_reg;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254, zero maps to zero) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = a;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [IDX_W-1:0] r);
    logic [7:0] rc;
    rc = 8'h00;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] rot_w, sub_w, t_w;
  logic [WORD_W-1:0] n0, n1, n2, n3;
  logic [IDX_W-1:0]  idx_next;
  logic              handshake;

  assign w0       = key_reg[127:96];
  assign w1       = key_reg[95:64];
  assign w2       = key_reg[63:32];
  assign w3       = key_reg[31:0];
  assign rot_w    = {w3[23:0], w3[31:24]};
  assign idx_next = IDX_W'(idx_reg + IDX_W'(1));

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign sub_w[8*g +: 8] = sbox(rot_w[8*g +: 8]);
  end

  assign t_w = sub_w ^ {rcon(idx_next), 24'h000000};
  assign n0  = w0 ^ t_w;
  assign n1  = w1 ^ n0;
  assign n2  = w2 ^ n1;
  assign n3  = w3 ^ n2;

  assign handshake = valid_reg && bus.key_ready;

  // Control FSM; key_reg doubles as the registered round_key output
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_reg   <= '0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            key_reg   <= bus.key_in;
            idx_reg   <= '0;
            valid_reg <= 1'b1;
            busy_reg  <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (handshake) begin
            if (idx_reg == IDX_W'(NR)) begin
              key_reg   <= '0;
              idx_reg   <= '0;
              valid_reg <= 1'b0;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state     <= IDLE;
            end else begin
              key_reg <= {n0, n1, n2, n3};
              idx_reg <= idx_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.round_key = key_reg;
  assign bus.round_idx = idx_reg;
  assign bus.key_valid = valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
endmodule

// File: tb/tb_aes_key_expand.sv
// Randomized self-checking bench for aes_key_expand against a word-array key expansion model.
module tb_aes_key_expand;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_key_expand_if bus();

  aes_key_expand dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_FIPS = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K1_ZERO = 128'h62636363626363636263636362636363;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   sbox_t [0:255];
  logic [127:0] m_keys [0:10];
  int           m_idx  = 0;
  bit           m_run  = 1'b0;
  bit           m_done = 1'b0;
  bit           chk_en = 1'b0;
  logic [127:0] acc_key[$];
  int           acc_idx[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Polynomial product then reduction by 0x11b
  function automatic logic [7:0] pmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Full 44-word expansion, returning round r
  function automatic logic [127:0] round_key_of(input logic [127:0] k, input int r);
    logic [31:0] w [0:43];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = subword({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc   = pmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && pmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 0;
      sbox_t[a] = s;
    end
  endtask

  // Transaction-level model of the stream, driven only by the bench's own inputs
  always @(posedge clk) begin
    if (rst) begin
      m_run = 1'b0; m_idx = 0; m_done = 1'b0; chk_en = 1'b1;
    end else if (!m_run) begin
      m_done = 1'b0;
      if (bus.start) begin
        for (int r = 0; r <= 10; r++) m_keys[r] = round_key_of(bus.key_in, r);
        m_run = 1'b1; m_idx = 0;
      end
    end else begin
      m_done = 1'b0;
      if (bus.key_ready) begin
        if (m_idx == 10) begin
          m_run = 1'b0; m_idx = 0; m_done = 1'b1;
        end else begin
          m_idx++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("round_key", bus.round_key, m_run ? m_keys[m_idx] : 128'h0);
      check("round_idx", 128'(bus.round_idx), 128'(m_idx));
      check("key_valid", 128'(bus.key_valid), 128'(m_run));
      check("busy",      128'(bus.busy),      128'(m_run));
      check("done",      128'(bus.done),      128'(m_done));
      if (bus.key_valid && bus.key_ready) begin
        acc_key.push_back(bus.round_key);
        acc_idx.push_back(int'(bus.round_idx));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready high; 1: ready 1,0,0,1; 2: random ready/start/key_in; 3: zero-key start at round 4
  task automatic run_key(input logic [127:0] k, input int mode, output int cyc);
    acc_key.delete();
    acc_idx.delete();
    bus.key_in = k;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 400) begin
      case (mode)
        1: bus.key_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        2: begin
          bus.key_ready = 1'($urandom_range(0, 1));
          bus.start     = ($urandom_range(0, 3) == 0);
          bus.key_in    = {$urandom, $urandom, $urandom, $urandom};
        end
        3: begin
          bus.key_ready = 1'b1;
          bus.start     = (bus.round_idx == 4'd4);
          bus.key_in    = '0;
        end
        default: bus.key_ready = 1'b1;
      endcase
      tick();
      cyc++;
    end
    bus.start     = 1'b0;
    bus.key_ready = 1'b1;
    check("done_seen", 128'(bus.done), 128'(1));
  endtask

  task automatic check_stream(input logic [127:0] k);
    check("n_accepted", 128'(acc_key.size()), 128'(11));
    for (int i = 0; i < acc_key.size() && i < 11; i++) begin
      check("acc_idx", 128'(acc_idx[i]), 128'(i));
      check("acc_key", acc_key[i], round_key_of(k, i));
    end
  endtask

  int cyc;
  logic [127:0] rk;

  initial begin
    bus.start     = 1'b0;
    bus.key_in    = '0;
    bus.key_ready = 1'b1;
    build_sbox();

    // Pin the model with hand-known values
    check("sbox_00", 128'(sbox_t[8'h00]), 128'h63);
    check("sbox_01", 128'(sbox_t[8'h01]), 128'h7c);
    check("sbox_53", 128'(sbox_t[8'h53]), 128'hed);
    check("sbox_ff", 128'(sbox_t[8'hff]), 128'h16);
    check("model_fips_1",  round_key_of(K_FIPS, 1),  K1_FIPS);
    check("model_fips_10", round_key_of(K_FIPS, 10), K10_FIPS);
    check("model_zero_1",  round_key_of('0, 1),      K1_ZERO);

    // T1 reset
    rst = 1'b1;
    tick(); tick();
    check("rst_round_key", bus.round_key, 128'h0);
    check("rst_valid", 128'(bus.key_valid), 128'(0));
    rst = 1'b0;
    tick();

    // T2 streaming FIPS-197 A.1
    run_key(K_FIPS, 0, cyc);
    check("done_latency", 128'(cyc), 128'(11));
    check_stream(K_FIPS);
    if (acc_key.size() == 11) begin
      check("t2_idx0",  acc_key[0],  K_FIPS);
      check("t2_idx1",  acc_key[1],  K1_FIPS);
      check("t2_idx10", acc_key[10], K10_FIPS);
    end
    tick();

    // T3 backpressure
    run_key(K_FIPS, 1, cyc);
    check_stream(K_FIPS);
    tick();

    // T4 start while busy
    run_key(K_FIPS, 3, cyc);
    check_stream(K_FIPS);
    if (acc_key.size() == 11) check("t4_idx10", acc_key[10], K10_FIPS);
    tick();

    // T5 reset mid-operation
    bus.key_in = K_FIPS; bus.start = 1'b1; bus.key_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    while (bus.round_idx != 4'd6 && cyc < 50) begin tick(); cyc++; end
    check("t5_reached_6", 128'(bus.round_idx), 128'(6));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_valid", 128'(bus.key_valid), 128'(0));
    check("t5_busy",  128'(bus.busy), 128'(0));
    check("t5_key",   bus.round_key, 128'h0);
    run_key('0, 0, cyc);
    check_stream('0);
    if (acc_key.size() > 1) check("t5_zero_idx1", acc_key[1], K1_ZERO);
    tick();

    // T6 start held through done
    bus.key_in = K_FIPS; bus.start = 1'b1; bus.key_ready = 1'b1;
    tick();
    cyc = 0;
    while (!bus.done && cyc < 50) begin tick(); cyc++; end
    check("t6_done1", 128'(bus.done), 128'(1));
    tick();
    check("t6_restart_key",   bus.round_key, K_FIPS);
    check("t6_restart_valid", 128'(bus.key_valid), 128'(1));
    check("t6_restart_idx",   128'(bus.round_idx), 128'(0));
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.done && cyc < 50) begin tick(); cyc++; end
    check("t6_done2", 128'(bus.done), 128'(1));
    tick();

    // Randomized runs
    for (int n = 0; n < 12; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      run_key(rk, 2, cyc);
      check_stream(rk);
      repeat ($urandom_range(0, 2)) tick();
    end

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
